// File: rtl/rs_branch_pkg.sv
// Shared definitions for the branch reservation station.
//   - Default widths and depth for rs_branch.
//   - Branch op encoding that dispatch places on disp_op_i.
package rs_branch_pkg;

    localparam int RS_ENT_NUM  = 4;   // entries, power of two, 2..8
    localparam int RS_DATA_LEN = 32;  // operand / immediate width
    localparam int RS_ADDR_LEN = 32;  // PC width
    localparam int RS_RRF_SEL  = 6;   // rename tag width
    localparam int RS_ALU_OP_W = 4;   // branch op width

    typedef enum logic [3:0] {
        BR_OP_BEQ  = 4'd0,
        BR_OP_BNE  = 4'd1,
        BR_OP_BLT  = 4'd4,
        BR_OP_BGE  = 4'd5,
        BR_OP_BLTU = 4'd6,
        BR_OP_BGEU = 4'd7,
        BR_OP_JAL  = 4'd8,
        BR_OP_JALR = 4'd9
    } br_op_e;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder.
//   req_i  in  N   request vector
//   idx_o  out W   index of the lowest set bit (0 when none)
//   any_o  out 1   at least one request set
module rs_prio_enc #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        // Walk from the top so the lowest set bit is the last writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/rs_branch.sv
// Branch reservation station.
// Holds dispatched branch/jump ops until both operands are valid, snoops two
// result buses for wakeup, and issues the lowest-index ready entry each cycle.
// Ports:
//   clk_i, reset_i (async, active-high), kill_i (flush all entries)
//   dispatch_i + disp_* : new entry; a non-valid operand carries its producer
//                         tag in its low RRF_SEL bits
//   bc0_*, bc1_*        : result broadcast buses (vld/tag/data)
//   full_o, count_o     : occupancy, derived from registered valid bits
//   issue_o + iss_*     : op presented to the branch unit; iss_* are 0 when idle
//   proto_err_o         : dispatch attempted while full with nothing issuing
//                         (the dispatch is dropped)
// Issue handshake: issue_o is a valid with an implicit always-ready consumer;
// the entry is retired at the same clock edge that sees issue_o=1.
module rs_branch
    import rs_branch_pkg::*;
#(
    parameter int ENTRY_NUM = RS_ENT_NUM,
    parameter int DATA_LEN  = RS_DATA_LEN,
    parameter int ADDR_LEN  = RS_ADDR_LEN,
    parameter int RRF_SEL   = RS_RRF_SEL,
    parameter int ALU_OP_W  = RS_ALU_OP_W
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          kill_i,
    input  logic                          dispatch_i,
    input  logic [ALU_OP_W-1:0]           disp_op_i,
    input  logic [DATA_LEN-1:0]           disp_src1_i,
    input  logic                          disp_src1_vld_i,
    input  logic [DATA_LEN-1:0]           disp_src2_i,
    input  logic                          disp_src2_vld_i,
    input  logic [ADDR_LEN-1:0]           disp_pc_i,
    input  logic [DATA_LEN-1:0]           disp_imm_i,
    input  logic [RRF_SEL-1:0]            disp_rrftag_i,
    input  logic                          disp_wrrf_i,
    input  logic                          bc0_vld_i,
    input  logic [RRF_SEL-1:0]            bc0_tag_i,
    input  logic [DATA_LEN-1:0]           bc0_data_i,
    input  logic                          bc1_vld_i,
    input  logic [RRF_SEL-1:0]            bc1_tag_i,
    input  logic [DATA_LEN-1:0]           bc1_data_i,
    output logic                          full_o,
    output logic [$clog2(ENTRY_NUM):0]    count_o,
    output logic                          issue_o,
    output logic [ALU_OP_W-1:0]           iss_op_o,
    output logic [DATA_LEN-1:0]           iss_src1_o,
    output logic [DATA_LEN-1:0]           iss_src2_o,
    output logic [DATA_LEN-1:0]           iss_imm_o,
    output logic [ADDR_LEN-1:0]           iss_pc_o,
    output logic [RRF_SEL-1:0]            iss_rrftag_o,
    output logic                          iss_wrrf_o,
    output logic                          proto_err_o
);

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = IDX_W + 1;

    // Control state (reset) and payload (no reset; only read when valid).
    logic [ENTRY_NUM-1:0] valid_q, valid_d;
    logic [ENTRY_NUM-1:0] s1v_q, s1v_d, s2v_q, s2v_d;
    logic [DATA_LEN-1:0]  s1_q  [ENTRY_NUM];
    logic [DATA_LEN-1:0]  s1_d  [ENTRY_NUM];
    logic [DATA_LEN-1:0]  s2_q  [ENTRY_NUM];
    logic [DATA_LEN-1:0]  s2_d  [ENTRY_NUM];
    logic [DATA_LEN-1:0]  imm_q [ENTRY_NUM];
    logic [DATA_LEN-1:0]  imm_d [ENTRY_NUM];
    logic [ADDR_LEN-1:0]  pc_q  [ENTRY_NUM];
    logic [ADDR_LEN-1:0]  pc_d  [ENTRY_NUM];
    logic [ALU_OP_W-1:0]  op_q  [ENTRY_NUM];
    logic [ALU_OP_W-1:0]  op_d  [ENTRY_NUM];
    logic [RRF_SEL-1:0]   tag_q [ENTRY_NUM];
    logic [RRF_SEL-1:0]   tag_d [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] wrrf_q, wrrf_d;

    logic [ENTRY_NUM-1:0] ready;
    logic [IDX_W-1:0]     iss_idx, free_idx, alloc_idx;
    logic                 free_any, disp_ok;
    logic [CNT_W-1:0]     cnt;

    // Operand capture: a non-valid operand whose tag matches a live
    // broadcast takes that data. bc0 wins a double match.
    function automatic logic [DATA_LEN:0] snoop(
        input logic                vld,
        input logic [DATA_LEN-1:0] val,
        input logic                b0v,
        input logic [RRF_SEL-1:0]  b0t,
        input logic [DATA_LEN-1:0] b0d,
        input logic                b1v,
        input logic [RRF_SEL-1:0]  b1t,
        input logic [DATA_LEN-1:0] b1d
    );
        snoop = {vld, val};
        if (!vld) begin
            if (b0v && (val[RRF_SEL-1:0] == b0t))      snoop = {1'b1, b0d};
            else if (b1v && (val[RRF_SEL-1:0] == b1t)) snoop = {1'b1, b1d};
        end
    endfunction

    assign ready = valid_q & s1v_q & s2v_q;

    rs_prio_enc #(.N(ENTRY_NUM)) u_ready_enc (
        .req_i (ready),
        .idx_o (iss_idx),
        .any_o (issue_o)
    );

    rs_prio_enc #(.N(ENTRY_NUM)) u_free_enc (
        .req_i (~valid_q),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    always_comb begin
        cnt = '0;
        for (int i = 0; i < ENTRY_NUM; i++) cnt = cnt + CNT_W'(valid_q[i]);
    end

    assign count_o = cnt;
    assign full_o  = (cnt == CNT_W'(ENTRY_NUM));

    // When full, the only usable slot is the one retiring this cycle.
    assign alloc_idx   = free_any ? free_idx : iss_idx;
    assign disp_ok     = dispatch_i && (!full_o || issue_o);
    assign proto_err_o = dispatch_i && full_o && !issue_o;

    assign iss_op_o     = issue_o ? op_q[iss_idx]   : '0;
    assign iss_src1_o   = issue_o ? s1_q[iss_idx]   : '0;
    assign iss_src2_o   = issue_o ? s2_q[iss_idx]   : '0;
    assign iss_imm_o    = issue_o ? imm_q[iss_idx]  : '0;
    assign iss_pc_o     = issue_o ? pc_q[iss_idx]   : '0;
    assign iss_rrftag_o = issue_o ? tag_q[iss_idx]  : '0;
    assign iss_wrrf_o   = issue_o ? wrrf_q[iss_idx] : 1'b0;

    always_comb begin
        valid_d = valid_q;
        s1v_d   = s1v_q;
        s2v_d   = s2v_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        op_d    = op_q;
        tag_d   = tag_q;
        wrrf_d  = wrrf_q;

        for (int i = 0; i < ENTRY_NUM; i++) begin
            {s1v_d[i], s1_d[i]} = snoop(s1v_q[i], s1_q[i], bc0_vld_i, bc0_tag_i, bc0_data_i,
                                        bc1_vld_i, bc1_tag_i, bc1_data_i);
            {s2v_d[i], s2_d[i]} = snoop(s2v_q[i], s2_q[i], bc0_vld_i, bc0_tag_i, bc0_data_i,
                                        bc1_vld_i, bc1_tag_i, bc1_data_i);
        end

        if (issue_o) valid_d[iss_idx] = 1'b0;

        // Dispatch after retire so a slot freed this cycle can be refilled.
        if (disp_ok) begin
            valid_d[alloc_idx] = 1'b1;
            {s1v_d[alloc_idx], s1_d[alloc_idx]} = snoop(disp_src1_vld_i, disp_src1_i,
                bc0_vld_i, bc0_tag_i, bc0_data_i, bc1_vld_i, bc1_tag_i, bc1_data_i);
            {s2v_d[alloc_idx], s2_d[alloc_idx]} = snoop(disp_src2_vld_i, disp_src2_i,
                bc0_vld_i, bc0_tag_i, bc0_data_i, bc1_vld_i, bc1_tag_i, bc1_data_i);
            imm_d[alloc_idx]  = disp_imm_i;
            pc_d[alloc_idx]   = disp_pc_i;
            op_d[alloc_idx]   = disp_op_i;
            tag_d[alloc_idx]  = disp_rrftag_i;
            wrrf_d[alloc_idx] = disp_wrrf_i;
        end

        if (kill_i) valid_d = '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            s1v_q   <= '0;
            s2v_q   <= '0;
        end else begin
            valid_q <= valid_d;
            s1v_q   <= s1v_d;
            s2v_q   <= s2v_d;
        end
    end

    always_ff @(posedge clk_i) begin
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        imm_q  <= imm_d;
        pc_q   <= pc_d;
        op_q   <= op_d;
        tag_q  <= tag_d;
        wrrf_q <= wrrf_d;
    end

endmodule

// File: tb/tb_rs_branch.sv
module tb_rs_branch;
    import rs_branch_pkg::*;

    localparam int EN = 4;
    localparam int DL = 32;
    localparam int AL = 32;
    localparam int RS = 6;
    localparam int OW = 4;
    localparam int CW = 3;
    localparam int PW = OW + DL + DL + AL + DL + RS + 1;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    logic          kill_i, dispatch_i;
    logic [OW-1:0] disp_op_i;
    logic [DL-1:0] disp_src1_i, disp_src2_i, disp_imm_i;
    logic          disp_src1_vld_i, disp_src2_vld_i, disp_wrrf_i;
    logic [AL-1:0] disp_pc_i;
    logic [RS-1:0] disp_rrftag_i;
    logic          bc0_vld_i, bc1_vld_i;
    logic [RS-1:0] bc0_tag_i, bc1_tag_i;
    logic [DL-1:0] bc0_data_i, bc1_data_i;
    logic          full_o, issue_o, iss_wrrf_o, proto_err_o;
    logic [CW-1:0] count_o;
    logic [OW-1:0] iss_op_o;
    logic [DL-1:0] iss_src1_o, iss_src2_o, iss_imm_o;
    logic [AL-1:0] iss_pc_o;
    logic [RS-1:0] iss_rrftag_o;

    rs_branch #(.ENTRY_NUM(EN), .DATA_LEN(DL), .ADDR_LEN(AL), .RRF_SEL(RS), .ALU_OP_W(OW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .kill_i(kill_i), .dispatch_i(dispatch_i),
        .disp_op_i(disp_op_i), .disp_src1_i(disp_src1_i), .disp_src1_vld_i(disp_src1_vld_i),
        .disp_src2_i(disp_src2_i), .disp_src2_vld_i(disp_src2_vld_i), .disp_pc_i(disp_pc_i),
        .disp_imm_i(disp_imm_i), .disp_rrftag_i(disp_rrftag_i), .disp_wrrf_i(disp_wrrf_i),
        .bc0_vld_i(bc0_vld_i), .bc0_tag_i(bc0_tag_i), .bc0_data_i(bc0_data_i),
        .bc1_vld_i(bc1_vld_i), .bc1_tag_i(bc1_tag_i), .bc1_data_i(bc1_data_i),
        .full_o(full_o), .count_o(count_o), .issue_o(issue_o), .iss_op_o(iss_op_o),
        .iss_src1_o(iss_src1_o), .iss_src2_o(iss_src2_o), .iss_imm_o(iss_imm_o),
        .iss_pc_o(iss_pc_o), .iss_rrftag_o(iss_rrftag_o), .iss_wrrf_o(iss_wrrf_o),
        .proto_err_o(proto_err_o)
    );

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pk(input br_op_e op, input logic [31:0] s1, input logic [31:0] s2,
                                         input logic [31:0] pc, input logic [31:0] imm, input int tag,
                                         input bit wrrf);
        pk = {op, s1, s2, pc, imm, RS'(tag), wrrf};
    endfunction

    function automatic logic [PW-1:0] dut_pk();
        dut_pk = {iss_op_o, iss_src1_o, iss_src2_o, iss_pc_o, iss_imm_o, iss_rrftag_o, iss_wrrf_o};
    endfunction

    // Mid-cycle: every issue must match the oldest expectation, idle issue must be all-zero.
    task automatic sb_check();
        if (issue_o === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_unexpected_issue", dut_pk(), '0);
            else                   chk("sb_issue", dut_pk(), exp_q.pop_front());
        end else begin
            chk("sb_idle_zero", {dut_pk(), issue_o}, '0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        #3;
        sb_check();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        kill_i = 1'b0; dispatch_i = 1'b0; disp_op_i = '0;
        disp_src1_i = '0; disp_src1_vld_i = 1'b0; disp_src2_i = '0; disp_src2_vld_i = 1'b0;
        disp_pc_i = '0; disp_imm_i = '0; disp_rrftag_i = '0; disp_wrrf_i = 1'b0;
        bc0_vld_i = 1'b0; bc0_tag_i = '0; bc0_data_i = '0;
        bc1_vld_i = 1'b0; bc1_tag_i = '0; bc1_data_i = '0;
    endtask

    task automatic disp(input br_op_e op, input logic [31:0] s1, input bit v1, input logic [31:0] s2,
                        input bit v2, input logic [31:0] pc, input logic [31:0] imm, input int tag,
                        input bit wrrf);
        dispatch_i = 1'b1; disp_op_i = op;
        disp_src1_i = s1; disp_src1_vld_i = v1; disp_src2_i = s2; disp_src2_vld_i = v2;
        disp_pc_i = pc; disp_imm_i = imm; disp_rrftag_i = RS'(tag); disp_wrrf_i = wrrf;
    endtask

    task automatic bc0(input int tag, input logic [31:0] data);
        bc0_vld_i = 1'b1; bc0_tag_i = RS'(tag); bc0_data_i = data;
    endtask

    task automatic bc1(input int tag, input logic [31:0] data);
        bc1_vld_i = 1'b1; bc1_tag_i = RS'(tag); bc1_data_i = data;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_i = 1'b1;
        idle();
        #2;
        chk("rst_count", PW'(count_o), '0);
        chk("rst_full", PW'(full_o), '0);
        chk("rst_issue", {dut_pk(), issue_o}, '0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Ready dispatch: issues the cycle after dispatch.
        disp(BR_OP_BEQ, 5, 1, 5, 1, 32'h100, 32'h20, 1, 0);
        exp_q.push_back(pk(BR_OP_BEQ, 5, 5, 32'h100, 32'h20, 1, 0));
        #1 chk("ready_no_same_cycle", PW'(issue_o), '0);
        tick(); idle();
        chk("ready_issue", PW'(issue_o), PW'(1));
        chk("ready_pc", PW'(iss_pc_o), PW'(32'h100));
        chk("ready_imm", PW'(iss_imm_o), PW'(32'h20));
        chk("ready_count", PW'(count_o), PW'(1));
        tick();
        chk("ready_count_after", PW'(count_o), '0);

        // Resident wakeup via bc1, two cycles after dispatch.
        disp(BR_OP_BNE, 7, 0, 3, 1, 32'h200, 32'h4, 2, 0);
        tick(); idle();
        chk("wake_wait0", PW'(issue_o), '0);
        tick();
        chk("wake_wait1", PW'(issue_o), '0);
        bc1(7, 32'hDEAD);
        exp_q.push_back(pk(BR_OP_BNE, 32'hDEAD, 3, 32'h200, 32'h4, 2, 0));
        #1 chk("wake_no_bypass", PW'(issue_o), '0);
        tick(); idle();
        chk("wake_issue", PW'(issue_o), PW'(1));
        chk("wake_src1", PW'(iss_src1_o), PW'(32'hDEAD));
        tick();
        chk("wake_count", PW'(count_o), '0);

        // Dispatch-time wakeup on bc0.
        disp(BR_OP_JALR, 1, 1, 9, 0, 32'h300, 32'h8, 3, 1);
        bc0(9, 32'h55);
        exp_q.push_back(pk(BR_OP_JALR, 1, 32'h55, 32'h300, 32'h8, 3, 1));
        tick(); idle();
        chk("dwake_issue", PW'(issue_o), PW'(1));
        tick();

        // Fill, wake slot 2, refill on full-with-issue, reject full-without-issue.
        for (int i = 0; i < 4; i++) begin
            disp(BR_OP_BLT, 10 + i, 0, i, 1, 32'h400 + 4 * i, i, 4 + i, 0);
            tick();
        end
        idle();
        chk("fill_full", PW'(full_o), PW'(1));
        chk("fill_count", PW'(count_o), PW'(4));
        bc0(12, 32'h12);
        exp_q.push_back(pk(BR_OP_BLT, 32'h12, 2, 32'h408, 2, 6, 0));
        tick(); idle();
        chk("fill_issue_pc", PW'(iss_pc_o), PW'(32'h408));
        chk("fill_full_while_issue", PW'(full_o), PW'(1));
        disp(BR_OP_BGE, 14, 0, 32'h77, 1, 32'h500, 32'h50, 9, 0);
        #1 chk("refill_no_proto", PW'(proto_err_o), '0);
        tick(); idle();
        chk("refill_count", PW'(count_o), PW'(4));
        chk("refill_no_issue", PW'(issue_o), '0);
        disp(BR_OP_BGEU, 1, 1, 2, 1, 32'h600, 32'h60, 10, 0);
        #1 chk("overflow_proto", PW'(proto_err_o), PW'(1));
        tick(); idle();
        chk("overflow_ignored", PW'(count_o), PW'(4));
        chk("overflow_no_issue", PW'(issue_o), '0);
        bc0(10, 32'hA0);
        bc1(11, 32'hB1);
        exp_q.push_back(pk(BR_OP_BLT, 32'hA0, 0, 32'h400, 0, 4, 0));
        exp_q.push_back(pk(BR_OP_BLT, 32'hB1, 1, 32'h404, 1, 5, 0));
        tick(); idle();
        bc0(14, 32'hE4);
        bc1(13, 32'hD3);
        exp_q.push_back(pk(BR_OP_BGE, 32'hE4, 32'h77, 32'h500, 32'h50, 9, 0));
        exp_q.push_back(pk(BR_OP_BLT, 32'hD3, 3, 32'h40C, 3, 7, 0));
        tick(); idle();
        tick(); tick(); tick();
        chk("drain_count", PW'(count_o), '0);

        // Priority: entries 1 and 3 woken together.
        for (int i = 0; i < 4; i++) begin
            disp(BR_OP_BEQ, 20 + i, 0, 32'h10 + i, 1, 32'h700 + 4 * i, 0, 11 + i, 0);
            tick();
        end
        idle();
        bc0(21, 32'h21);
        bc1(23, 32'h23);
        exp_q.push_back(pk(BR_OP_BEQ, 32'h21, 32'h11, 32'h704, 0, 12, 0));
        exp_q.push_back(pk(BR_OP_BEQ, 32'h23, 32'h13, 32'h70C, 0, 14, 0));
        tick(); idle();
        chk("prio_first", PW'(iss_pc_o), PW'(32'h704));
        tick();
        chk("prio_second", PW'(iss_pc_o), PW'(32'h70C));
        tick();
        chk("prio_done_issue", PW'(issue_o), '0);
        chk("prio_done_count", PW'(count_o), PW'(2));

        // Kill beats concurrent dispatch and wakeup.
        disp(BR_OP_BNE, 24, 0, 0, 1, 32'h800, 0, 15, 0);
        tick(); idle();
        chk("kill_pre_count", PW'(count_o), PW'(3));
        kill_i = 1'b1;
        disp(BR_OP_BEQ, 1, 1, 1, 1, 32'h900, 0, 16, 0);
        bc0(20, 32'h99);
        tick(); idle();
        chk("kill_count", PW'(count_o), '0);
        chk("kill_issue", PW'(issue_o), '0);
        tick();
        chk("kill_issue_later", PW'(issue_o), '0);

        // Issue is still presented in a kill cycle.
        disp(BR_OP_BEQ, 2, 1, 2, 1, 32'hA00, 0, 17, 0);
        exp_q.push_back(pk(BR_OP_BEQ, 2, 2, 32'hA00, 0, 17, 0));
        tick(); idle();
        kill_i = 1'b1;
        chk("kill_cycle_issue", PW'(issue_o), PW'(1));
        tick(); idle();
        chk("kill_cycle_count", PW'(count_o), '0);

        // Reset mid-operation with three live entries.
        disp(BR_OP_BNE, 30, 0, 0, 1, 32'hB00, 0, 18, 0);
        tick();
        disp(BR_OP_BNE, 31, 0, 0, 1, 32'hB04, 0, 19, 0);
        tick();
        disp(BR_OP_BEQ, 3, 1, 3, 1, 32'hB08, 0, 20, 0);
        tick(); idle();
        chk("mid_count", PW'(count_o), PW'(3));
        chk("mid_issue", PW'(issue_o), PW'(1));
        #1 reset_i = 1'b1;
        #1;
        chk("mid_rst_count", PW'(count_o), '0);
        chk("mid_rst_full", PW'(full_o), '0);
        chk("mid_rst_issue", {dut_pk(), issue_o}, '0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        tick();
        chk("post_rst_count", PW'(count_o), '0);
        chk("sb_empty", PW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
